// File: rtl/alu_pipe.sv
// Two-stage pipelined execute ALU with saturating arithmetic, valid/ready handshake on
// both sides and a commit-time {Z,V,N} flag register.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int LANE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             illegal,
    output logic [2:0]       flags
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NLANES = WIDTH / LANE;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9
    } op_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE-1:0]  LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
    localparam logic [LANE-1:0]  LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             ill_q;
    logic             wr_zvn_q;
    logic             wr_z_q;
    logic [2:0]       flags_q;

    logic [WIDTH-1:0] res_d;
    logic             err_d;
    logic             ill_d;
    logic             wr_zvn_d;
    logic             wr_z_d;

    logic             s2_adv;
    logic             s1_adv;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0] red_acc;
    logic [WIDTH-1:0] padd;
    logic             padd_err;
    logic [LANE:0]    lane_sum;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = !rst && s1_adv;

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign error     = err_q;
    assign illegal   = ill_q;
    assign flags     = flags_q;

    assign sum_ext  = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
    assign diff_ext = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
    assign sh       = s1_b_q[SHAMT_W-1:0];

    // Byte reduction: modular WIDTH-bit accumulation equals full-precision sum
    // sign-extended or truncated to WIDTH.
    always_comb begin
        red_acc = '0;
        for (int i = 0; i < NBYTES; i++) begin
            red_acc = red_acc
                    + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                    + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
        end
    end

    always_comb begin
        padd     = '0;
        padd_err = 1'b0;
        lane_sum = '0;
        for (int l = 0; l < NLANES; l++) begin
            lane_sum = {s1_a_q[l*LANE+LANE-1], s1_a_q[l*LANE +: LANE]}
                     + {s1_b_q[l*LANE+LANE-1], s1_b_q[l*LANE +: LANE]};
            if (lane_sum[LANE] != lane_sum[LANE-1]) begin
                padd[l*LANE +: LANE] = lane_sum[LANE] ? LANE_MIN : LANE_MAX;
                padd_err = 1'b1;
            end else begin
                padd[l*LANE +: LANE] = lane_sum[LANE-1:0];
            end
        end
    end

    always_comb begin
        res_d    = '0;
        err_d    = 1'b0;
        ill_d    = 1'b0;
        wr_zvn_d = 1'b0;
        wr_z_d   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                err_d    = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                res_d    = err_d ? (sum_ext[WIDTH] ? MIN_NEG : MAX_POS) : sum_ext[WIDTH-1:0];
                wr_zvn_d = 1'b1;
            end
            OP_SUB: begin
                err_d    = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
                res_d    = err_d ? (diff_ext[WIDTH] ? MIN_NEG : MAX_POS) : diff_ext[WIDTH-1:0];
                wr_zvn_d = 1'b1;
            end
            OP_XOR: begin
                res_d  = s1_a_q ^ s1_b_q;
                wr_z_d = 1'b1;
            end
            OP_RED:    res_d = red_acc;
            OP_SLL: begin
                res_d  = s1_a_q << sh;
                wr_z_d = 1'b1;
            end
            OP_SRA: begin
                res_d  = $signed(s1_a_q) >>> sh;
                wr_z_d = 1'b1;
            end
            OP_ROR: begin
                res_d  = (s1_a_q >> sh) | (s1_a_q << (WIDTH - int'(sh)));
                wr_z_d = 1'b1;
            end
            OP_PADDSB: begin
                res_d = padd;
                err_d = padd_err;
            end
            OP_LW, OP_SW: res_d = s1_a_q + s1_b_q;
            default:      ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
            ill_q      <= 1'b0;
            wr_zvn_q   <= 1'b0;
            wr_z_q     <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (s2_valid_q && out_ready) begin
                if (wr_zvn_q) begin
                    flags_q <= {res_q == '0, err_q, res_q[WIDTH-1]};
                end else if (wr_z_q) begin
                    flags_q[2] <= (res_q == '0);
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q    <= res_d;
                    err_q    <= err_d;
                    ill_q    <= ill_d;
                    wr_zvn_q <= wr_zvn_d;
                    wr_z_q   <= wr_z_d;
                end
            end
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q <= opcode;
                    s1_a_q  <= a;
                    s1_b_q  <= b;
                end
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle 16-bit execute ALU.
- Adds generic datapath width, saturating arithmetic, and a committed Z/V/N flag register.
- Uses a valid/ready handshake on both sides so the core can stall execute without dropping operations.
- Sits between decode/operand-read and the writeback/branch-condition logic.

Parameters:
WIDTH, 16, datapath width; multiple of 8, >= 16.
SHAMT_W, 4, shift-amount bits taken from b; must equal log2(WIDTH).
LANE, 4, PADDSB lane width; must divide WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operation presented.
in_ready  output  1  stage 1 can accept; transfer when in_valid && in_ready.
opcode  input  4  operation select.
a  input  WIDTH  operand 1 (rs).
b  input  WIDTH  operand 2 (rt or immediate, already extended).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts; commit when out_valid && out_ready.
result  output  WIDTH  operation result.
error  output  1  overflow/saturation occurred for this result.
illegal  output  1  opcode not supported.
flags  output  3  committed {Z,V,N}.

Behaviour:
Reset:
- rst high at an edge clears both stage valids, result, error, illegal and flags to 0.
- in_ready is 0 while rst is high.
- Reset mid-operation discards all in-flight operations; no commit or flag update occurs for them.

Pipeline:
- S1 registers opcode, a and b. S2 registers result, error and illegal.
- s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
- Unstalled latency: an op accepted on edge N drives out_valid after edge N+1.
- Throughput is 1 op/cycle.
- Order is preserved and nothing is dropped or duplicated.
- Stalled S2 holds result, error and illegal stable.

Operations (signed two's complement):
- 0000 ADD, saturating.
  - On signed overflow: result = 0111..1 if the true sum is positive, else 1000..0; error = 1.
- 0001 SUB (a - b), saturating, same rule as ADD.
- 0010 XOR, error = 0.
- 0011 RED: signed sum of all WIDTH/8 bytes of a plus all bytes of b.
  - Computed at full precision, then sign-extended or truncated to WIDTH.
  - No saturation; error = 0.
- 0100 SLL a by b[SHAMT_W-1:0], zero fill.
- 0101 SRA a by b[SHAMT_W-1:0], sign fill.
- 0110 ROR a by b[SHAMT_W-1:0].
- Shift or rotate by 0 returns a.
- 0111 PADDSB: independent LANE-bit signed adds per lane, each saturated.
  - error = OR of all lane saturations.
- 1000, 1001 (LW/SW address): a + b, wrap-around, no saturation, error = 0.
- 1010-1111: result = 0, illegal = 1, error = 0.

Flags:
- Updated only on commit (out_valid && out_ready). Z = (result == 0); N = result MSB; V = error.
- ADD and SUB write Z, V and N.
- XOR, SLL, SRA and ROR write Z only; V and N hold.
- RED, PADDSB, LW/SW and illegal ops leave all flags unchanged.
- Flags written by an op become visible the cycle after its commit. There is no forwarding to in-flight ops.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> result 0x7FFF, error 1; after commit flags Z0 V1 N0. SUB a=0x8000 b=0x0001 -> 0x8000, error 1, N1.
- SUB 0x1234-0x1234 -> 0x0000, flags Z1 V0 N0. Then XOR 0x00FF^0x00FF -> 0x0000, Z1, V/N unchanged. Then PADDSB -> flags unchanged.
- PADDSB a=0x7878 b=0x1111 -> result 0x7979, error 1. RED a=0x7F7F b=0x7F7F -> 0x01FC. RED a=0x8080 b=0x0000 -> 0xFF00.
- SLL 0x0001 by 15 -> 0x8000; SRA 0x8000 by 3 -> 0xF000; ROR 0x0001 by 1 -> 0x8000; ROR x by 0 -> x. Opcode 1100 -> result 0, illegal 1.
- Back-pressure: out_ready=0, issue 3 ops back-to-back -> 2 accepted, then in_ready=0 and result held. Release out_ready -> all 3 emerge in order on consecutive cycles; flags reflect the last committed op.
- Reset with both stages full and out_ready=0 -> next cycle out_valid=0, flags=000, result=0. First op after deassert emerges 2 cycles later with a correct value.
